// File: rtl/pulse_width_encoder_pkg.sv
// Shared definitions for the pulse-width encoder.
// - Default timing parameters.
// - Number of low quarters for each bit value.
// - FSM state encoding.
package pulse_width_encoder_pkg;

    localparam int DEFAULT_QUARTER_CYCLES    = 25;
    localparam int DEFAULT_QWIDTH            = 5;
    localparam int DEFAULT_STOP_LOW_QUARTERS = 2;

    // Quarters the line is held low at the start of a bit cell.
    localparam logic [1:0] Q_LOW_ONE  = 2'd1;
    localparam logic [1:0] Q_LOW_ZERO = 2'd3;

    typedef enum logic [2:0] {
        IDLE_REQ = 3'd0,
        IDLE_CHK = 3'd1,
        BIT      = 3'd2,
        STOP     = 3'd3,
        GUARD    = 3'd4
    } pwe_state_t;

    function automatic logic [1:0] low_quarters(input logic bit_val);
        return bit_val ? Q_LOW_ONE : Q_LOW_ZERO;
    endfunction

endpackage

// File: rtl/pulse_width_encoder_if.sv
// Serial-side link between serializer (master) and pulse_width_encoder (slave).
//   ser_data   : bit value, meaningful only while ser_strobe is high
//   ser_strobe : level flag, high while serializer holds a bit for us
//   ser_ready  : single-cycle request from the encoder
// Handshake: a bit is transferred on a rising clk edge when ser_ready and
// ser_strobe are both high in the cycle before it. The serializer advances
// to its next bit after such an edge and must not raise ser_strobe without
// a pending request. The encoder ignores ser_strobe while ser_ready is low.
interface pulse_width_encoder_if;
    logic ser_data;
    logic ser_strobe;
    logic ser_ready;

    modport master (output ser_data, output ser_strobe, input ser_ready);
    modport slave  (input ser_data, input ser_strobe, output ser_ready);
endinterface

// File: rtl/pulse_width_encoder_quarter_timer.sv
// Quarter-bit timebase for the pulse-width encoder.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous hold at sub=0, quarter=0
//   sub          : cycle count inside the current quarter, 0..QUARTER_CYCLES-1
//   quarter      : quarter index inside the cell, wraps 3->0
//   quarter_tick : high on the last cycle of every quarter
//   cell_end     : high on the last cycle of quarter 3
module quarter_timer
    import pulse_width_encoder_pkg::*;
#(
    parameter int QUARTER_CYCLES = DEFAULT_QUARTER_CYCLES,
    parameter int QWIDTH         = DEFAULT_QWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic [QWIDTH-1:0] sub,
    output logic [1:0]        quarter,
    output logic              quarter_tick,
    output logic              cell_end
);

    localparam logic [QWIDTH-1:0] SUB_LAST = QWIDTH'(QUARTER_CYCLES - 1);

    assign quarter_tick = (sub == SUB_LAST);
    assign cell_end     = quarter_tick && (quarter == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub     <= '0;
            quarter <= 2'd0;
        end else if (clear) begin
            sub     <= '0;
            quarter <= 2'd0;
        end else if (quarter_tick) begin
            sub     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            sub     <= sub + QWIDTH'(1);
        end
    end

endmodule

// File: rtl/pulse_width_encoder.sv
// Pulse-width encoder: pulls bits from the serializer and drives them onto
// an open-drain line as 4-quarter cells (1 = 1 low + 3 high, 0 = 3 low +
// 1 high), then appends a stop bit (STOP_LOW_QUARTERS low + 1 high guard).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ser        : serializer link (slave side: ser_data, ser_strobe, ser_ready)
//   drive_low  : 1 pulls the line low, 0 releases it
//   busy       : high from the first accepted bit until the guard ends
//   done       : one-cycle pulse on the last cycle of the guard
//   state_dbg  : current FSM state
module pulse_width_encoder
    import pulse_width_encoder_pkg::*;
#(
    parameter int QUARTER_CYCLES    = DEFAULT_QUARTER_CYCLES,
    parameter int QWIDTH            = DEFAULT_QWIDTH,
    parameter int STOP_LOW_QUARTERS = DEFAULT_STOP_LOW_QUARTERS
) (
    input  logic                        clk,
    input  logic                        reset,
    pulse_width_encoder_if.slave        ser,
    output logic                        drive_low,
    output logic                        busy,
    output logic                        done,
    output pwe_state_t                  state_dbg
);

    // ser_ready is registered, so it is launched one cycle early to be high
    // in the cycle quarter=3, sub=QUARTER_CYCLES-2. With only two cycles per
    // quarter that launch point falls on the last cycle of quarter 2.
    localparam logic [1:0]        READY_Q   = (QUARTER_CYCLES >= 3) ? 2'd3 : 2'd2;
    localparam logic [QWIDTH-1:0] READY_SUB = (QUARTER_CYCLES >= 3) ?
                                              QWIDTH'(QUARTER_CYCLES - 3) :
                                              QWIDTH'(QUARTER_CYCLES - 1);
    localparam logic [QWIDTH-1:0] SUB_PRE   = QWIDTH'(QUARTER_CYCLES - 2);
    localparam logic [1:0]        STOP_LAST_Q = 2'(STOP_LOW_QUARTERS - 1);
    localparam logic [1:0]        GUARD_Q     = 2'(STOP_LOW_QUARTERS);

    pwe_state_t        state;
    logic              cur_bit;
    logic              next_bit;
    logic              next_valid;
    logic              ser_ready_q;
    logic              timer_clear;
    logic              ready_set;
    logic [QWIDTH-1:0] sub;
    logic [1:0]        quarter;
    logic              quarter_tick;
    logic              cell_end;

    assign ser.ser_ready = ser_ready_q;
    assign state_dbg     = state;

    // The timebase only runs while a packet is on the line, so the first
    // cell always starts at quarter 0, sub 0.
    assign timer_clear = (state == IDLE_REQ) || (state == IDLE_CHK);
    assign ready_set   = (quarter == READY_Q) && (sub == READY_SUB);

    quarter_timer #(
        .QUARTER_CYCLES (QUARTER_CYCLES),
        .QWIDTH         (QWIDTH)
    ) u_quarter_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (timer_clear),
        .sub          (sub),
        .quarter      (quarter),
        .quarter_tick (quarter_tick),
        .cell_end     (cell_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE_REQ;
            ser_ready_q <= 1'b0;
            drive_low   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cur_bit     <= 1'b0;
            next_bit    <= 1'b0;
            next_valid  <= 1'b0;
        end else begin
            ser_ready_q <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE_REQ: begin
                    ser_ready_q <= 1'b1;
                    state       <= IDLE_CHK;
                end
                IDLE_CHK: begin
                    if (ser.ser_strobe) begin
                        cur_bit   <= ser.ser_data;
                        busy      <= 1'b1;
                        drive_low <= 1'b1;
                        state     <= BIT;
                    end else begin
                        state     <= IDLE_REQ;
                    end
                end
                BIT: begin
                    if (ready_set) begin
                        ser_ready_q <= 1'b1;
                    end
                    // Sampled one cycle before cell_end, so it never
                    // collides with the reload below.
                    if (ser_ready_q && ser.ser_strobe) begin
                        next_bit   <= ser.ser_data;
                        next_valid <= 1'b1;
                    end
                    if (cell_end) begin
                        // Both the next cell and the stop bit start low.
                        drive_low <= 1'b1;
                        if (next_valid) begin
                            cur_bit    <= next_bit;
                            next_valid <= 1'b0;
                        end else begin
                            state      <= STOP;
                        end
                    end else if (quarter_tick &&
                                 (quarter == low_quarters(cur_bit) - 2'd1)) begin
                        drive_low <= 1'b0;
                    end
                end
                STOP: begin
                    if (quarter_tick && (quarter == STOP_LAST_Q)) begin
                        drive_low <= 1'b0;
                        state     <= GUARD;
                    end
                end
                GUARD: begin
                    // done and the busy fall land on the edge entering the
                    // final guard cycle.
                    if ((quarter == GUARD_Q) && (sub == SUB_PRE)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (quarter_tick) begin
                        state <= IDLE_REQ;
                    end
                end
                default: begin
                    state <= IDLE_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_encoder.sv
module tb_pulse_width_encoder;
    import pulse_width_encoder_pkg::*;

    localparam int QC   = 4;
    localparam int CELL = 4 * QC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pulse_width_encoder_if if0 ();
    pulse_width_encoder_if if1 ();

    logic       dl0, b0, d0, dl1, b1, d1;
    pwe_state_t st0, st1;

    pulse_width_encoder #(.QUARTER_CYCLES(QC), .QWIDTH(3), .STOP_LOW_QUARTERS(2)) dut0 (
        .clk(clk), .reset(reset), .ser(if0.slave),
        .drive_low(dl0), .busy(b0), .done(d0), .state_dbg(st0)
    );

    pulse_width_encoder #(.QUARTER_CYCLES(QC), .QWIDTH(3), .STOP_LOW_QUARTERS(1)) dut1 (
        .clk(clk), .reset(reset), .ser(if1.slave),
        .drive_low(dl1), .busy(b1), .done(d1), .state_dbg(st1)
    );

    // sel chooses which DUT the serializer model answers and the checks observe
    logic sel = 1'b0;
    logic dl, bz, dn, rdy;
    assign dl  = sel ? dl1 : dl0;
    assign bz  = sel ? b1  : b0;
    assign dn  = sel ? d1  : d0;
    assign rdy = sel ? if1.ser_ready : if0.ser_ready;

    // ---------------- serializer model ----------------
    logic bit_q[$];
    logic inject = 1'b0;
    logic take;
    int   pops = 0;

    initial begin
        logic sv, dv;
        if0.ser_strobe = 1'b0; if0.ser_data = 1'b0;
        if1.ser_strobe = 1'b0; if1.ser_data = 1'b0;
        take = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                take = 1'b0;
            end else if (take && bit_q.size() > 0) begin
                void'(bit_q.pop_front());
                pops++;
            end
            sv = inject || (bit_q.size() > 0);
            dv = inject ? 1'b1 : ((bit_q.size() > 0) ? bit_q[0] : 1'b0);
            if0.ser_strobe = sv; if0.ser_data = dv;
            if1.ser_strobe = sv; if1.ser_data = dv;
            take = !inject && rdy && (bit_q.size() > 0);
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Push n bits (MSB first from bits[n-1]) and check the whole waveform
    // cycle by cycle against hand-derived cell shapes.
    task automatic run_packet(input string tag, input logic [15:0] bits, input int n,
                              input int slq, input int inj_from, input int inj_to);
        int   lat, total, w, c, rdy_cnt;
        logic b, exp_dl;
        pops = 0;
        for (int i = n - 1; i >= 0; i--) bit_q.push_back(bits[i]);
        lat = 0;
        while (dl !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat <= 4), 32'd1);
        if (dl !== 1'b1) return;
        total   = n * CELL + (slq + 1) * QC;
        rdy_cnt = 0;
        for (int t = 0; t < total; t++) begin
            if (t == inj_from) inject = 1'b1;
            if (t == inj_to)   inject = 1'b0;
            if (t < n * CELL) begin
                c = t / CELL;
                w = t % CELL;
                b = bits[n - 1 - c];
                exp_dl = (w < (b ? 1 : 3) * QC);
            end else begin
                w = t - n * CELL;
                exp_dl = (w < slq * QC);
            end
            check($sformatf("%s_dl_t%0d", tag, t), 32'(dl), 32'(exp_dl));
            check($sformatf("%s_done_t%0d", tag, t), 32'(dn), 32'(t == total - 1));
            check($sformatf("%s_busy_t%0d", tag, t), 32'(bz), 32'(t != total - 1));
            if (inj_from >= 0 && t >= inj_from && t <= inj_to + 1)
                check($sformatf("%s_next_valid_t%0d", tag, t), 32'(dut0.next_valid), 32'd0);
            if (rdy) rdy_cnt++;
            step();
        end
        check({tag, "_done_after"}, 32'(dn), 32'd0);
        check({tag, "_dl_after"}, 32'(dl), 32'd0);
        check({tag, "_ready_pulses"}, 32'(rdy_cnt), 32'(n));
        check({tag, "_bits_taken"}, 32'(pops), 32'(n));
    endtask

    task automatic reset_all();
        reset = 1'b1;
        inject = 1'b0;
        bit_q.delete();
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        check("rst_drive_low", 32'(dl0), 32'd0);
        check("rst_busy", 32'(b0), 32'd0);
        check("rst_done", 32'(d0), 32'd0);
        check("rst_ready", 32'(if0.ser_ready), 32'd0);
        check("rst_state", 32'(st0), 32'(IDLE_REQ));
        check("rst_next_valid", 32'(dut0.next_valid), 32'd0);
        reset = 1'b0;

        // idle polling: ready alternates 1,0,1,0 starting one edge after release
        for (int k = 1; k <= 100; k++) begin
            step();
            check($sformatf("idle_ready_k%0d", k), 32'(rdy), 32'(k % 2));
            check($sformatf("idle_dl_k%0d", k), 32'(dl), 32'd0);
            check($sformatf("idle_busy_k%0d", k), 32'(bz), 32'd0);
        end

        // single byte 0x80: one 1-cell, seven 0-cells, stop, done at t=139
        run_packet("b80", 16'h0080, 8, 2, -1, -1);
        repeat (5) step();

        // 0xA5 then 0x3C back to back: 16 contiguous cells, one stop
        run_packet("a53c", 16'hA53C, 16, 2, -1, -1);
        repeat (5) step();

        // reset at quarter 1 of cell 3 of 0xFF
        for (int i = 7; i >= 0; i--) bit_q.push_back(1'b1);
        for (int k = 0; k < 10 && dl !== 1'b1; k++) step();
        check("rst_mid_rise", 32'(dl), 32'd1);
        repeat (2 * CELL + QC + 1) step();
        check("rst_mid_busy_before", 32'(bz), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy_async", 32'(b0), 32'd0);
        check("rst_mid_dl_async", 32'(dl0), 32'd0);
        check("rst_mid_ready_async", 32'(if0.ser_ready), 32'd0);
        check("rst_mid_state_async", 32'(st0), 32'(IDLE_REQ));
        bit_q.delete();
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check($sformatf("post_rst_ready_k%0d", k), 32'(rdy), 32'(k % 2));
            check($sformatf("post_rst_dl_k%0d", k), 32'(dl), 32'd0);
            check($sformatf("post_rst_busy_k%0d", k), 32'(bz), 32'd0);
            check($sformatf("post_rst_done_k%0d", k), 32'(dn), 32'd0);
        end

        // reset while the line is held low releases it without a clock edge
        bit_q.push_back(1'b0);
        for (int k = 0; k < 10 && dl !== 1'b1; k++) step();
        step();
        check("rst_low_before", 32'(dl0), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_low_async", 32'(dl0), 32'd0);
        bit_q.delete();
        step();
        reset_all();

        // one-quarter stop: 12 low, 4 high, 4 low, 4 high, done
        sel = 1'b1;
        reset_all();
        run_packet("slq1", 16'h0000, 1, 1, -1, -1);

        // strobe injected mid-cell, outside the sampling cycle
        sel = 1'b0;
        reset_all();
        run_packet("inject", 16'h0000, 1, 2, 4, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
